// File: rtl/fft_frame_sink.sv
// fft_frame_sink: double-buffered capture of one FFT output frame per bank.
// The write side fills the free bank in arrival order; the read side serves
// random-access bin reads from the completed bank until the consumer releases it.
module fft_frame_sink #(
    parameter int unsigned N = 256,
    parameter int unsigned W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic                 sop_in,
    input  logic [W-1:0]         d_re,
    input  logic [W-1:0]         d_im,
    input  logic                 rd_req,
    input  logic [$clog2(N)-1:0] rd_addr,
    input  logic                 frame_done,
    output logic                 frame_rdy,
    output logic                 rd_valid,
    output logic [W-1:0]         rd_re,
    output logic [W-1:0]         rd_im,
    output logic                 overflow,
    output logic                 len_err
);

    localparam int unsigned AW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } wr_state_e;

    // Both banks live in one array; the bank pointer is the address MSB.
    logic [2*W-1:0] mem [0:2*N-1];

    wr_state_e      state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic           wr_bank_q, wr_bank_d;
    logic           rd_bank_q, rd_bank_d;
    logic [1:0]     full_q, full_d;
    logic           frame_rdy_q, frame_rdy_d;
    logic           overflow_q, overflow_d;
    logic           len_err_q, len_err_d;
    logic           rd_valid_q;
    logic [W-1:0]   rd_re_q, rd_im_q;

    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic           set_full;
    logic           release_bank;
    logic [2*W-1:0] rd_word;

    // Write FSM next-state: frame alignment, length checking and bank hand-off.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_bank_d  = wr_bank_q;
        wr_en      = 1'b0;
        wr_addr    = '0;
        set_full   = 1'b0;
        overflow_d = 1'b0;
        len_err_d  = 1'b0;
        case (state_q)
            IDLE, DROP: begin
                if (valid_in && sop_in) begin
                    if (!full_q[wr_bank_q]) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        cnt_d   = AW'(1);
                        state_d = FILL;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = DROP;
                    end
                end
            end
            FILL: begin
                if (valid_in) begin
                    wr_en = 1'b1;
                    if (sop_in) begin
                        // Restart in the same bank; the partial frame is overwritten.
                        len_err_d = 1'b1;
                        wr_addr   = '0;
                        cnt_d     = AW'(1);
                    end else begin
                        wr_addr = cnt_q;
                        if (cnt_q == AW'(N - 1)) begin
                            set_full  = 1'b1;
                            wr_bank_d = ~wr_bank_q;
                            cnt_d     = '0;
                            state_d   = IDLE;
                        end else begin
                            cnt_d = cnt_q + AW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bank ownership: completion and release may hit different banks in one cycle.
    always_comb begin
        release_bank = frame_done && frame_rdy_q;
        full_d       = full_q;
        if (set_full) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (release_bank) begin
            full_d[rd_bank_q] = 1'b0;
        end
        rd_bank_d   = rd_bank_q ^ release_bank;
        frame_rdy_d = full_d[rd_bank_d];
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            frame_rdy_q <= 1'b0;
            overflow_q  <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            frame_rdy_q <= frame_rdy_d;
            overflow_q  <= overflow_d;
            len_err_q   <= len_err_d;
        end
    end

    // Sample storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && rst_n) begin
            mem[{wr_bank_q, wr_addr}] <= {d_re, d_im};
        end
    end

    assign rd_word = mem[{rd_bank_q, rd_addr}];

    // Read port: one-cycle latency, served from the bank held before any release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_re_q    <= '0;
            rd_im_q    <= '0;
        end else if (rd_req && frame_rdy_q) begin
            rd_valid_q <= 1'b1;
            rd_re_q    <= rd_word[2*W-1:W];
            rd_im_q    <= rd_word[W-1:0];
        end else begin
            rd_valid_q <= 1'b0;
            rd_re_q    <= '0;
            rd_im_q    <= '0;
        end
    end

    assign frame_rdy = frame_rdy_q;
    assign rd_valid  = rd_valid_q;
    assign rd_re     = rd_re_q;
    assign rd_im     = rd_im_q;
    assign overflow  = overflow_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_fft_frame_sink.sv
// Directed bench for fft_frame_sink with N=256, W=16.
module tb_fft_frame_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        sop_in;
    logic [15:0] d_re;
    logic [15:0] d_im;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        frame_done;
    logic        frame_rdy;
    logic        rd_valid;
    logic [15:0] rd_re;
    logic [15:0] rd_im;
    logic        overflow;
    logic        len_err;

    int tests = 0;
    int fails = 0;

    logic [15:0] got_re  [0:255];
    logic [15:0] got_im  [0:255];
    logic        got_vld [0:255];

    fft_frame_sink #(.N(256), .W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .sop_in     (sop_in),
        .d_re       (d_re),
        .d_im       (d_im),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .frame_done (frame_done),
        .frame_rdy  (frame_rdy),
        .rd_valid   (rd_valid),
        .rd_re      (rd_re),
        .rd_im      (rd_im),
        .overflow   (overflow),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ere(input int base, input int k);
        return 16'(base + k);
    endfunction

    function automatic logic [15:0] eim(input int base, input int k);
        return 16'(0 - (base + k));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic sop, input logic [15:0] re, input logic [15:0] im);
        valid_in = 1'b1;
        sop_in   = sop;
        d_re     = re;
        d_im     = im;
        tick();
        valid_in = 1'b0;
        sop_in   = 1'b0;
    endtask

    task automatic send_range(input int base, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            send_sample(k == 0, ere(base, k), eim(base, k));
        end
    endtask

    task automatic release_frame();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    // Back-to-back reads of every bin, one per cycle, captured for later comparison.
    task automatic capture_frame();
        for (int k = 0; k < 256; k++) begin
            rd_req  = 1'b1;
            rd_addr = 8'(k);
            tick();
            got_re[k]  = rd_re;
            got_im[k]  = rd_im;
            got_vld[k] = rd_valid;
        end
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tests++;
        if ({frame_rdy, rd_valid, overflow, len_err} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 0000", {frame_rdy, rd_valid, overflow, len_err});
        end
        tests++;
        if ({rd_re, rd_im} !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: got %h expected 00000000", {rd_re, rd_im});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        int bad;
        int first_bad;
        rd_req  = 1'b1;
        rd_addr = 8'd3;
        tick();
        rd_req = 1'b0;
        tests++;
        if ({rd_valid, rd_re, rd_im} !== 33'h0) begin
            fails++;
            $display("FAIL read_not_ready: got %h expected 0", {rd_valid, rd_re, rd_im});
        end
        send_sample(1'b0, 16'hdead, 16'hbeef);
        send_range(0, 0, 254);
        tests++;
        if (frame_rdy !== 1'b0) begin
            fails++;
            $display("FAIL rdy_before_last: got %b expected 0", frame_rdy);
        end
        send_range(0, 255, 255);
        tests++;
        if (frame_rdy !== 1'b1) begin
            fails++;
            $display("FAIL rdy_after_last: got %b expected 1", frame_rdy);
        end
        capture_frame();
        bad = 0;
        first_bad = -1;
        for (int k = 0; k < 256; k++) begin
            if (got_vld[k] !== 1'b1 || got_re[k] !== ere(0, k) || got_im[k] !== eim(0, k)) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL frame_index: %0d bad bins, first %0d got %h/%h expected %h/%h",
                     bad, first_bad, got_re[first_bad], got_im[first_bad], ere(0, first_bad), eim(0, first_bad));
        end
        release_frame();
        tests++;
        if (frame_rdy !== 1'b0) begin
            fails++;
            $display("FAIL rdy_after_release: got %b expected 0", frame_rdy);
        end
    endtask

    task automatic test_gaps();
        int bad;
        int first_bad;
        for (int k = 0; k < 256; k++) begin
            send_range(16'h1000, k, k);
            if (k == 254) begin
                tests++;
                if (frame_rdy !== 1'b0) begin
                    fails++;
                    $display("FAIL gap_rdy_early: got %b expected 0", frame_rdy);
                end
            end
            if (k == 255) begin
                tests++;
                if (frame_rdy !== 1'b1) begin
                    fails++;
                    $display("FAIL gap_rdy_last: got %b expected 1", frame_rdy);
                end
            end
            if (k % 2 == 1) tick();
        end
        capture_frame();
        bad = 0;
        first_bad = -1;
        for (int k = 0; k < 256; k++) begin
            if (got_vld[k] !== 1'b1 || got_re[k] !== ere(16'h1000, k) || got_im[k] !== eim(16'h1000, k)) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL gap_frame: %0d bad bins, first %0d got %h/%h", bad, first_bad, got_re[first_bad], got_im[first_bad]);
        end
        release_frame();
    endtask

    task automatic test_overflow();
        int bad;
        int first_bad;
        send_range(16'h2000, 0, 255);
        send_range(16'h3000, 0, 255);
        send_range(16'h4000, 0, 0);
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_pulse: got %b expected 1", overflow);
        end
        send_range(16'h4000, 1, 1);
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL overflow_single: got %b expected 0", overflow);
        end
        send_range(16'h4000, 2, 255);
        for (int f = 0; f < 2; f++) begin
            capture_frame();
            bad = 0;
            first_bad = -1;
            for (int k = 0; k < 256; k++) begin
                if (got_vld[k] !== 1'b1 || got_re[k] !== ere(16'h2000 + f * 16'h1000, k) ||
                    got_im[k] !== eim(16'h2000 + f * 16'h1000, k)) begin
                    if (bad == 0) first_bad = k;
                    bad++;
                end
            end
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL ovf_frame%0d: %0d bad bins, first %0d got %h/%h", f + 1, bad, first_bad,
                         got_re[first_bad], got_im[first_bad]);
            end
            release_frame();
        end
        tests++;
        if (frame_rdy !== 1'b0) begin
            fails++;
            $display("FAIL ovf_third_dropped: got %b expected 0", frame_rdy);
        end
    endtask

    task automatic test_len_err();
        int bad;
        int first_bad;
        logic seen_rdy;
        send_range(16'h5000, 0, 99);
        send_range(16'h6000, 0, 0);
        tests++;
        if (len_err !== 1'b1) begin
            fails++;
            $display("FAIL len_err_pulse: got %b expected 1", len_err);
        end
        seen_rdy = 1'b0;
        for (int k = 1; k < 256; k++) begin
            send_range(16'h6000, k, k);
            if (k == 1) begin
                tests++;
                if (len_err !== 1'b0) begin
                    fails++;
                    $display("FAIL len_err_single: got %b expected 0", len_err);
                end
            end
            if (k < 255 && frame_rdy !== 1'b0) seen_rdy = 1'b1;
        end
        tests++;
        if (seen_rdy !== 1'b0) begin
            fails++;
            $display("FAIL len_partial_rdy: got %b expected 0", seen_rdy);
        end
        tests++;
        if (frame_rdy !== 1'b1) begin
            fails++;
            $display("FAIL len_new_rdy: got %b expected 1", frame_rdy);
        end
        capture_frame();
        bad = 0;
        first_bad = -1;
        for (int k = 0; k < 256; k++) begin
            if (got_vld[k] !== 1'b1 || got_re[k] !== ere(16'h6000, k) || got_im[k] !== eim(16'h6000, k)) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL len_frame: %0d bad bins, first %0d got %h/%h", bad, first_bad, got_re[first_bad], got_im[first_bad]);
        end
    endtask

    // Frame 0x6000 is still held for reading on entry.
    task automatic test_same_cycle();
        int bad;
        int first_bad;
        send_range(16'h7000, 0, 254);
        frame_done = 1'b1;
        rd_req     = 1'b1;
        rd_addr    = 8'd5;
        send_range(16'h7000, 255, 255);
        frame_done = 1'b0;
        rd_req     = 1'b0;
        tests++;
        if ({rd_valid, rd_re, rd_im} !== {1'b1, ere(16'h6000, 5), eim(16'h6000, 5)}) begin
            fails++;
            $display("FAIL read_before_release: got %h expected %h", {rd_valid, rd_re, rd_im},
                     {1'b1, ere(16'h6000, 5), eim(16'h6000, 5)});
        end
        tests++;
        if (frame_rdy !== 1'b1) begin
            fails++;
            $display("FAIL same_cycle_rdy: got %b expected 1", frame_rdy);
        end
        capture_frame();
        bad = 0;
        first_bad = -1;
        for (int k = 0; k < 256; k++) begin
            if (got_vld[k] !== 1'b1 || got_re[k] !== ere(16'h7000, k) || got_im[k] !== eim(16'h7000, k)) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL same_cycle_frame: %0d bad bins, first %0d got %h/%h", bad, first_bad, got_re[first_bad], got_im[first_bad]);
        end
        release_frame();
        tests++;
        if (frame_rdy !== 1'b0) begin
            fails++;
            $display("FAIL same_cycle_empty: got %b expected 0", frame_rdy);
        end
    endtask

    task automatic test_reset_mid_fill();
        int bad;
        int first_bad;
        send_range(16'h0800, 0, 255);
        send_range(16'h0900, 0, 49);
        rd_req  = 1'b1;
        rd_addr = 8'd3;
        tick();
        rd_req = 1'b0;
        tests++;
        if ({rd_valid, rd_re} !== {1'b1, ere(16'h0800, 3)}) begin
            fails++;
            $display("FAIL pre_reset_read: got %h expected %h", {rd_valid, rd_re}, {1'b1, ere(16'h0800, 3)});
        end
        rd_req = 1'b1;
        rst_n  = 1'b0;
        tick();
        rst_n  = 1'b1;
        rd_req = 1'b0;
        tests++;
        if ({frame_rdy, rd_valid, overflow, len_err, rd_re, rd_im} !== 36'h0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got %h expected 0", {frame_rdy, rd_valid, overflow, len_err, rd_re, rd_im});
        end
        send_range(16'h0A00, 0, 255);
        tests++;
        if (frame_rdy !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_rdy: got %b expected 1", frame_rdy);
        end
        capture_frame();
        bad = 0;
        first_bad = -1;
        for (int k = 0; k < 256; k++) begin
            if (got_vld[k] !== 1'b1 || got_re[k] !== ere(16'h0A00, k) || got_im[k] !== eim(16'h0A00, k)) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL post_reset_frame: %0d bad bins, first %0d got %h/%h", bad, first_bad, got_re[first_bad], got_im[first_bad]);
        end
        release_frame();
        tests++;
        if (frame_rdy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_release: got %b expected 0", frame_rdy);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        valid_in   = 1'b0;
        sop_in     = 1'b0;
        d_re       = '0;
        d_im       = '0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        frame_done = 1'b0;
        test_reset();
        test_single_frame();
        test_gaps();
        test_overflow();
        test_len_err();
        test_same_cycle();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_frame_sink.md
FFT_FRAME_SINK -- requirements
Module: fft_frame_sink

Interface
REQ-001 Parameter N, default 256: frame length in complex samples; power of two.
REQ-002 Parameter W, default 16: bit width of each real/imag component, two's complement.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port valid_in  input  1  sample strobe from the FFT output stream.
REQ-006 Port sop_in  input  1  start-of-frame; qualified by valid_in.
REQ-007 Port d_re / d_im  input  W each  sample real/imag.
REQ-008 Port rd_req  input  1  read request from consumer.
REQ-009 Port rd_addr  input  log2(N)  bin index to read.
REQ-010 Port frame_done  input  1  consumer releases the current read frame (1-cycle pulse).
REQ-011 Port frame_rdy  output  1  a complete frame is available for reading.
REQ-012 Port rd_valid  output  1  rd_re/rd_im valid this cycle.
REQ-013 Port rd_re / rd_im  output  W each  read data.
REQ-014 Port overflow  output  1  1-cycle pulse: frame dropped, no free bank.
REQ-015 Port len_err  output  1  1-cycle pulse: sop_in arrived before the frame completed.

Function
REQ-016 Storage SHALL be two banks (0,1) of N x 2W; each bank has flag full; wr_bank and rd_bank pointers each 1 bit.
REQ-017 Write FSM states SHALL be IDLE, FILL, DROP.
REQ-018 IDLE: valid_in&sop_in with bank[wr_bank] not full -> write sample at addr 0, cnt=1, go FILL; with bank full -> overflow pulse, go DROP; valid_in without sop_in -> sample ignored.
REQ-019 FILL: valid_in&!sop_in -> write at addr cnt, cnt+1; cycles with valid_in=0 hold state (gaps allowed).
REQ-020 FILL: write of sample N-1 SHALL set full[wr_bank], toggle wr_bank, return to IDLE.
REQ-021 FILL: valid_in&sop_in -> len_err pulse, partial frame discarded, sample written at addr 0 of the same bank, cnt=1, stay FILL.
REQ-022 DROP: discard all samples; valid_in&sop_in re-evaluates exactly as in IDLE (same cycle).
REQ-023 Samples SHALL be stored at their arrival index unchanged (no reordering, no scaling).
REQ-024 frame_rdy SHALL equal full[rd_bank], registered; rises the cycle after the edge that wrote sample N-1.
REQ-025 rd_req&frame_rdy at edge k -> rd_valid=1 and rd_re/rd_im=bank[rd_bank][rd_addr] after edge k (1-cycle latency); back-to-back reads every cycle supported.
REQ-026 rd_req with frame_rdy=0 -> rd_valid=0, rd_re/rd_im=0.
REQ-027 frame_done with frame_rdy=1 SHALL clear full[rd_bank] and toggle rd_bank; frame_done with frame_rdy=0 ignored.
REQ-028 Frame completion and frame_done in the same cycle on different banks SHALL both take effect; frames are delivered in arrival order.
REQ-029 rd_req and frame_done in the same cycle: read served from the bank before release.
REQ-030 overflow and len_err SHALL be single-cycle pulses, never held.

Reset
REQ-031 rst_n=0 at an edge: state=IDLE, cnt=0, wr_bank=rd_bank=0, full[0]=full[1]=0, frame_rdy=0, rd_valid=0, rd_re=rd_im=0, overflow=0, len_err=0.
REQ-032 Bank memory contents SHALL NOT be reset; reset mid-FILL abandons the partial frame.

Verification
REQ-033 One frame d_re=index, d_im=-index, no gaps -> frame_rdy=1 the cycle after sample 255; reading addr 0..255 returns re=k, im=-k with 1-cycle latency.
REQ-034 Frame with valid_in=0 gaps every 3rd cycle -> identical stored contents; frame_rdy only after the 256th valid sample.
REQ-035 Three frames sent, no frame_done -> frames 1,2 stored, overflow pulse at frame 3 sop, frame 3 discarded; after two frame_done pulses, frame 1 then frame 2 read back.
REQ-036 sop_in at sample 100 of a frame -> len_err pulse one cycle, new frame completes after 256 further samples, frame_rdy never asserted for the partial frame.
REQ-037 Frame 2 completes in the same cycle frame_done releases frame 1 -> frame_rdy stays 1, next read returns frame 2 data.
REQ-038 rst_n=0 for one cycle at sample 50 -> all outputs at reset values; a subsequent full frame is captured correctly in bank 0.
